// File: rtl/video_timing_pkg.sv
// Shared raster timing descriptions and helpers for the video timing generator.
package video_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t VGA_640x480  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t SVGA_800x600 = '{800, 40, 128, 88, 600, 1, 4, 23};

    function automatic int h_total(input timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int v_total(input timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_pix_stb_gen.sv
// Phase-accumulator pixel strobe: the carry out of a 16-bit accumulator
// becomes a one-clock strobe at STB_INC/65536 of the base clock rate.
module pix_stb_gen #(
    parameter logic [15:0] STB_INC = 16'h8000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_stb
);

    logic [15:0] r_acc;
    logic        r_stb;
    logic [16:0] w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, STB_INC};

    // Accumulate the increment every clock; the carry is the strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_stb <= 1'b0;
        end else if (i_restart) begin
            r_acc <= '0;
            r_stb <= 1'b0;
        end else begin
            r_acc <= w_sum[15:0];
            r_stb <= w_sum[16];
        end
    end

    assign o_stb = r_stb;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with integer pixel replication and a
// multiplier-free framebuffer address (row base accumulates FB_W per row).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter logic [15:0] STB_INC  = 16'h8000,
    parameter int          SCALE_X  = 2,
    parameter int          SCALE_Y  = 2,
    parameter int          CNT_W    = 11,
    parameter int          ADDR_W   = 17
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_restart,
    output logic              o_pix_stb,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_active,
    output logic              o_blank,
    output logic              o_line_start,
    output logic              o_frame_start,
    output logic              o_frame_end,
    output logic [CNT_W-1:0]  o_x,
    output logic [CNT_W-1:0]  o_y,
    output logic [CNT_W-1:0]  o_fb_x,
    output logic [CNT_W-1:0]  o_fb_y,
    output logic [ADDR_W-1:0] o_addr
);

    localparam timing_t T = '{H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP};
    localparam int H_TOTAL = h_total(T);
    localparam int V_TOTAL = v_total(T);
    localparam int FB_W    = H_ACTIVE / SCALE_X;
    localparam int FB_H    = V_ACTIVE / SCALE_Y;

    localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]  HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]  VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]  VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0]  SX_LAST    = CNT_W'(SCALE_X - 1);
    localparam logic [CNT_W-1:0]  SY_LAST    = CNT_W'(SCALE_Y - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FB_W);

    // Reject parameter sets that cannot produce a consistent raster.
    generate
        if (H_ACTIVE % SCALE_X != 0) begin : g_bad_scale_x
            $error("H_ACTIVE must be a multiple of SCALE_X");
        end
        if (V_ACTIVE % SCALE_Y != 0) begin : g_bad_scale_y
            $error("V_ACTIVE must be a multiple of SCALE_Y");
        end
        if (STB_INC == 16'h0000) begin : g_bad_stb
            $error("STB_INC must be nonzero");
        end
        if (longint'(FB_W) * longint'(FB_H) - 1 >= (longint'(1) << ADDR_W)) begin : g_bad_addr
            $error("ADDR_W too narrow for FB_W*FB_H");
        end
    endgenerate

    logic             w_stb;
    logic [CNT_W-1:0] r_h, r_v;
    logic [CNT_W-1:0] r_sx, r_sy, r_fb_x, r_fb_y;
    logic [ADDR_W-1:0] r_row_base;
    logic             w_h_wrap, w_v_wrap, w_active;

    pix_stb_gen #(
        .STB_INC (STB_INC)
    ) u_pix_stb_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (i_restart),
        .o_stb     (w_stb)
    );

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);
    assign w_active = (r_h <= H_ACT_LAST) && (r_v <= V_ACT_LAST);

    // Horizontal/vertical raster counters, advanced once per pixel strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_restart) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_stb) begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= w_v_wrap ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Framebuffer address state; the last visible column and row are held
    // through blanking so the final pixel address stays put until the frame wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sx       <= '0;
            r_sy       <= '0;
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_row_base <= '0;
        end else if (i_restart) begin
            r_sx       <= '0;
            r_sy       <= '0;
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_row_base <= '0;
        end else if (w_stb) begin
            if (w_h_wrap && w_v_wrap) begin
                r_sx       <= '0;
                r_sy       <= '0;
                r_fb_x     <= '0;
                r_fb_y     <= '0;
                r_row_base <= '0;
            end else if (w_h_wrap && (r_v < V_ACT_LAST)) begin
                r_fb_x <= '0;
                r_sx   <= '0;
                if (r_sy == SY_LAST) begin
                    r_sy       <= '0;
                    r_fb_y     <= r_fb_y + 1'b1;
                    r_row_base <= r_row_base + ROW_STEP;
                end else begin
                    r_sy <= r_sy + 1'b1;
                end
            end else if (w_active && (r_h != H_ACT_LAST)) begin
                if (r_sx == SX_LAST) begin
                    r_sx   <= '0;
                    r_fb_x <= r_fb_x + 1'b1;
                end else begin
                    r_sx <= r_sx + 1'b1;
                end
            end
        end
    end

    assign o_pix_stb     = w_stb;
    assign o_hs          = ((r_h >= HS_START) && (r_h < HS_END)) ? HS_POL : ~HS_POL;
    assign o_vs          = ((r_v >= VS_START) && (r_v < VS_END)) ? VS_POL : ~VS_POL;
    assign o_active      = w_active;
    assign o_blank       = ~w_active;
    assign o_line_start  = w_stb && (r_h == '0);
    assign o_frame_start = w_stb && (r_h == '0) && (r_v == '0);
    assign o_frame_end   = w_stb && (r_h == H_ACT_LAST) && (r_v == V_ACT_LAST);
    assign o_x           = r_h;
    assign o_y           = r_v;
    assign o_fb_x        = r_fb_x;
    assign o_fb_y        = r_fb_y;
    assign o_addr        = r_row_base + ADDR_W'(r_fb_x);

endmodule
